// File: rtl/ysyx_23060025_axi_arbiter.sv
`timescale 1ns/1ps
// ysyx_23060025_axi_arbiter
//
// Shares one AXI master port between the instruction fetch unit (read only)
// and the load/store unit (read and write). Only one transaction is in flight
// at a time. IFU and LSU are granted round-robin. A registered watchdog raises
// a sticky flag when a granted transaction stays open too long.
//
// Ports:
//   clk, rstn                  clock and synchronous active-low reset
//   ifu_ar*/ifu_r*             IFU read address / read data channels
//   lsu_ar*/lsu_r*             LSU read address / read data channels
//   lsu_aw*/lsu_w*/lsu_b*      LSU write address / data / response channels
//   s_ar*/s_r*                 downstream slave read channels
//   s_aw*/s_w*/s_b*            downstream slave write channels
//   timeout_o                  sticky watchdog flag, cleared only by reset
module ysyx_23060025_axi_arbiter #(
    parameter int ADDR_LEN    = 32,
    parameter int DATA_LEN    = 32,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                    clk,
    input  logic                    rstn,
    // IFU read
    input  logic [ADDR_LEN-1:0]     ifu_araddr_i,
    input  logic                    ifu_arvalid_i,
    output logic                    ifu_arready_o,
    output logic [DATA_LEN-1:0]     ifu_rdata_o,
    output logic [1:0]              ifu_rresp_o,
    output logic                    ifu_rvalid_o,
    input  logic                    ifu_rready_i,
    // LSU read
    input  logic [ADDR_LEN-1:0]     lsu_araddr_i,
    input  logic                    lsu_arvalid_i,
    output logic                    lsu_arready_o,
    output logic [DATA_LEN-1:0]     lsu_rdata_o,
    output logic [1:0]              lsu_rresp_o,
    output logic                    lsu_rvalid_o,
    input  logic                    lsu_rready_i,
    // LSU write
    input  logic [ADDR_LEN-1:0]     lsu_awaddr_i,
    input  logic                    lsu_awvalid_i,
    output logic                    lsu_awready_o,
    input  logic [DATA_LEN-1:0]     lsu_wdata_i,
    input  logic [DATA_LEN/8-1:0]   lsu_wstrb_i,
    input  logic                    lsu_wvalid_i,
    output logic                    lsu_wready_o,
    output logic [1:0]              lsu_bresp_o,
    output logic                    lsu_bvalid_o,
    input  logic                    lsu_bready_i,
    // Slave read
    output logic [ADDR_LEN-1:0]     s_araddr_o,
    output logic                    s_arvalid_o,
    input  logic                    s_arready_i,
    input  logic [DATA_LEN-1:0]     s_rdata_i,
    input  logic [1:0]              s_rresp_i,
    input  logic                    s_rvalid_i,
    output logic                    s_rready_o,
    input  logic                    s_rlast_i,
    // Slave write
    output logic [ADDR_LEN-1:0]     s_awaddr_o,
    output logic                    s_awvalid_o,
    input  logic                    s_awready_i,
    output logic [DATA_LEN-1:0]     s_wdata_o,
    output logic [DATA_LEN/8-1:0]   s_wstrb_o,
    output logic                    s_wvalid_o,
    input  logic                    s_wready_i,
    input  logic [1:0]              s_bresp_i,
    input  logic                    s_bvalid_i,
    output logic                    s_bready_o,
    // Watchdog
    output logic                    timeout_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD_IFU = 2'd1,
        RD_LSU = 2'd2,
        WR_LSU = 2'd3
    } state_t;

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] WD_MAX = CNT_W'(TIMEOUT_CYC);

    state_t           state, state_next;
    logic             rr_ptr, rr_ptr_next;
    logic             aw_done, w_done;
    logic [CNT_W-1:0] wd_cnt, wd_cnt_next;
    logic             ifu_req, lsu_req, grant_ifu;

    assign ifu_req   = ifu_arvalid_i;
    assign lsu_req   = lsu_arvalid_i | lsu_awvalid_i;
    // rr_ptr=0 prefers the IFU when both masters are asking.
    assign grant_ifu = ifu_req & (~lsu_req | ~rr_ptr);

    // Watchdog counts granted cycles and saturates so it can never wrap back
    // below the threshold.
    always_comb begin
        wd_cnt_next = wd_cnt;
        if (state == IDLE) begin
            wd_cnt_next = '0;
        end else if (wd_cnt != WD_MAX) begin
            wd_cnt_next = wd_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= IDLE;
            rr_ptr    <= 1'b0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            wd_cnt    <= '0;
            timeout_o <= 1'b0;
        end else begin
            state  <= state_next;
            rr_ptr <= rr_ptr_next;
            wd_cnt <= wd_cnt_next;
            if (wd_cnt_next == WD_MAX) begin
                timeout_o <= 1'b1;
            end
            // AW/W completion flags live only for the duration of one write.
            if (state == WR_LSU && !(s_bvalid_i && lsu_bready_i)) begin
                if (s_awvalid_o && s_awready_i) aw_done <= 1'b1;
                if (s_wvalid_o && s_wready_i)   w_done  <= 1'b1;
            end else begin
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end
        end
    end

    // Next state and all channel muxing. Everything is zero unless the
    // current (registered) state grants that path, so a master valid can
    // never reach the slave in the same cycle it is raised.
    always_comb begin
        state_next    = state;
        rr_ptr_next   = rr_ptr;
        ifu_arready_o = 1'b0;
        ifu_rdata_o   = '0;
        ifu_rresp_o   = 2'b00;
        ifu_rvalid_o  = 1'b0;
        lsu_arready_o = 1'b0;
        lsu_rdata_o   = '0;
        lsu_rresp_o   = 2'b00;
        lsu_rvalid_o  = 1'b0;
        lsu_awready_o = 1'b0;
        lsu_wready_o  = 1'b0;
        lsu_bresp_o   = 2'b00;
        lsu_bvalid_o  = 1'b0;
        s_araddr_o    = '0;
        s_arvalid_o   = 1'b0;
        s_rready_o    = 1'b0;
        s_awaddr_o    = '0;
        s_awvalid_o   = 1'b0;
        s_wdata_o     = '0;
        s_wstrb_o     = '0;
        s_wvalid_o    = 1'b0;
        s_bready_o    = 1'b0;
        case (state)
            IDLE: begin
                if (ifu_req || lsu_req) begin
                    if (grant_ifu) begin
                        state_next  = RD_IFU;
                        rr_ptr_next = 1'b1;
                    end else begin
                        // Inside the LSU a pending write beats a pending read.
                        state_next  = lsu_awvalid_i ? WR_LSU : RD_LSU;
                        rr_ptr_next = 1'b0;
                    end
                end
            end
            RD_IFU: begin
                s_araddr_o    = ifu_araddr_i;
                s_arvalid_o   = ifu_arvalid_i;
                s_rready_o    = ifu_rready_i;
                ifu_arready_o = s_arready_i;
                ifu_rvalid_o  = s_rvalid_i;
                ifu_rdata_o   = s_rdata_i;
                ifu_rresp_o   = s_rresp_i;
                if (s_rvalid_i && ifu_rready_i && s_rlast_i) state_next = IDLE;
            end
            RD_LSU: begin
                s_araddr_o    = lsu_araddr_i;
                s_arvalid_o   = lsu_arvalid_i;
                s_rready_o    = lsu_rready_i;
                lsu_arready_o = s_arready_i;
                lsu_rvalid_o  = s_rvalid_i;
                lsu_rdata_o   = s_rdata_i;
                lsu_rresp_o   = s_rresp_i;
                if (s_rvalid_i && lsu_rready_i && s_rlast_i) state_next = IDLE;
            end
            WR_LSU: begin
                s_awaddr_o    = lsu_awaddr_i;
                s_awvalid_o   = lsu_awvalid_i & ~aw_done;
                lsu_awready_o = s_awready_i & ~aw_done;
                s_wdata_o     = lsu_wdata_i;
                s_wstrb_o     = lsu_wstrb_i;
                s_wvalid_o    = lsu_wvalid_i & ~w_done;
                lsu_wready_o  = s_wready_i & ~w_done;
                s_bready_o    = lsu_bready_i;
                lsu_bvalid_o  = s_bvalid_i;
                lsu_bresp_o   = s_bresp_i;
                if (s_bvalid_i && lsu_bready_i) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: doc/ysyx_23060025_axi_arbiter.md
Name: ysyx_23060025_axi_arbiter

Overview:
- Shares the core's single AXI master port between the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read and write).
- Sits between the IFU/LSU AXI-lite style request ports and the downstream slave (AXI SRAM or the SoC master port).
- Exactly one transaction is outstanding at a time.
- Round-robin grant between IFU and LSU; a registered watchdog flags a stuck transaction.

Parameters:
- ADDR_LEN, 32, address width.
- DATA_LEN, 32, data width.
- TIMEOUT_CYC, 1024, cycles a granted transaction may stay open before timeout_o sets.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rstn  in  1  synchronous active-low reset.
- ifu_araddr_i  in  ADDR_LEN  IFU read address.
- ifu_arvalid_i  in  1  IFU read address valid.
- ifu_arready_o  out  1  IFU read address ready.
- ifu_rdata_o  out  DATA_LEN  IFU read data.
- ifu_rresp_o  out  2  IFU read response.
- ifu_rvalid_o  out  1  IFU read data valid.
- ifu_rready_i  in  1  IFU read data ready.
- lsu_araddr_i, lsu_arvalid_i, lsu_arready_o, lsu_rdata_o, lsu_rresp_o, lsu_rvalid_o, lsu_rready_i: same directions and widths as the IFU read ports, for the LSU.
- lsu_awaddr_i  in  ADDR_LEN  LSU write address.
- lsu_awvalid_i  in  1  LSU write address valid.
- lsu_awready_o  out  1  LSU write address ready.
- lsu_wdata_i  in  DATA_LEN  LSU write data.
- lsu_wstrb_i  in  DATA_LEN/8  LSU byte strobes.
- lsu_wvalid_i  in  1  LSU write data valid.
- lsu_wready_o  out  1  LSU write data ready.
- lsu_bresp_o  out  2  LSU write response.
- lsu_bvalid_o  out  1  LSU write response valid.
- lsu_bready_i  in  1  LSU write response ready.
- s_araddr_o, s_arvalid_o, s_arready_i, s_rdata_i, s_rresp_i, s_rvalid_i, s_rready_o, s_rlast_i: slave read channels (widths as above; s_rlast_i is 1 bit).
- s_awaddr_o, s_awvalid_o, s_awready_i, s_wdata_o, s_wstrb_o, s_wvalid_o, s_wready_i, s_bresp_i, s_bvalid_i, s_bready_o: slave write channels (widths as above).
- timeout_o  out  1  sticky watchdog flag.

Behaviour:
- State machine states: IDLE, RD_IFU, RD_LSU, WR_LSU. Reset state: IDLE.
- Reset values: rr_ptr=0 (IFU preferred), aw_done=0, w_done=0, wd_cnt=0, timeout_o=0.
- In IDLE, all slave valid/ready outputs and all master ready/valid outputs are 0.
- Request terms: ifu_req = ifu_arvalid_i; lsu_req = lsu_arvalid_i | lsu_awvalid_i.
- LSU internal priority: if lsu_awvalid_i and lsu_arvalid_i are both high, the write wins.
- Arbitration (IDLE only): only one requester active -> grant it. Both active -> grant IFU if rr_ptr=0, else LSU.
- On grant, rr_ptr flips to point at the other master. Next state is registered, so there is a 1-cycle arbitration bubble; there is no combinational path from a master's valid to a slave valid.
- RD_x: s_araddr_o/s_arvalid_o and s_rready_o are driven combinationally from master x. x_arready_o = s_arready_i; x_rvalid_o = s_rvalid_i; rdata/rresp pass through unchanged, including SLVERR/DECERR.
- RD_x exit: the non-granted master sees ready=0 and valid=0. The state returns to IDLE on the cycle s_rvalid_i & s_rready_o & s_rlast_i.
- WR_LSU, AW and W channels:
  - AW and W are forwarded independently.
  - aw_done sets on AW handshake and w_done sets on W handshake.
  - s_awvalid_o is gated by !aw_done; s_wvalid_o is gated by !w_done.
  - AW and W may complete in the same cycle or in either order.
- WR_LSU, B channel and exit:
  - The B channel is forwarded unchanged.
  - On B handshake: next state IDLE, aw_done=0, w_done=0.
  - A B response arriving before both aw_done and w_done is still forwarded; there is no protocol check.
- A read request waiting during a write (or the reverse) stays pending. The master must hold valid (AXI rule); the arbiter never drops it.
- Back-to-back: a new grant is possible in the cycle after return to IDLE. Minimum of 1 idle cycle between transactions.
- Watchdog: wd_cnt clears in IDLE and increments each cycle in a granted state, saturating at TIMEOUT_CYC.
- When wd_cnt reaches TIMEOUT_CYC, timeout_o sets and holds until reset. The transaction is not aborted.
- Reset mid-transaction (rstn=0 at an edge): state goes to IDLE and all counters/flags clear. The outstanding slave transaction is abandoned; the slave is reset by the same rstn.

Test Plan:
- Single IFU read: ifu_arvalid=1, addr=0x8000_0000; slave returns 0x0000_0413, rlast=1. Required: s_arvalid rises 1 cycle after request; ifu_rdata=0x0000_0413; state back to IDLE; LSU outputs stay 0 throughout.
- Simultaneous IFU+LSU reads after reset, repeated 4 times. Required grant order IFU, LSU, IFU, LSU; rr_ptr alternates.
- LSU write with W before AW: wdata=0xDEAD_BEEF, wstrb=0xF, addr=0x8000_0100; W handshakes 2 cycles before AW. Required: exactly one W and one AW beat on the slave; lsu_bvalid forwarded with bresp=00; state back to IDLE.
- LSU awvalid and arvalid together, with IFU also requesting and rr_ptr=1. Required order: write first, then IFU read, then LSU read.
- Slave stalls rvalid for TIMEOUT_CYC=16 cycles (parameter override). Required: timeout_o=1 at cycle 16 and stays 1 after completion; the read still completes normally.
- rstn low for 1 cycle during RD_LSU. Required next cycle: state=IDLE, all valid/ready=0, rr_ptr=0, timeout_o=0.
